program_memory_loader: RTL and testbench

- Boot-time controller for the writable program memory (instruction RAM) of the single-cycle RISC-V core.
- After a load request it holds the CPU in reset and takes ownership of the memory port.
- It assembles an incoming little-endian byte stream into 32-bit instruction words and writes them sequentially from TEXT_BASE.
- When loading completes it returns the memory address port to the CPU fetch path (PC) and releases the core.

---
 rtl/program_memory_loader.sv | 144 ++++++++++++++
 tb/tb_program_memory_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_loader.sv
// Boot loader for the instruction RAM: holds the core in reset, packs a little-endian
// byte stream into words and writes them upward from TEXT_BASE, then hands the port back.
module program_memory_loader #(
    parameter int          MEMORY_DEPTH = 64,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] TEXT_BASE    = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Load_Start_i,
    input  logic [15:0]           Word_Count_i,
    input  logic [7:0]            Byte_i,
    input  logic                  Byte_Valid_i,
    output logic                  Byte_Ready_o,
    input  logic [31:0]           PC_i,
    output logic [31:0]           Mem_Address_o,
    output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
    output logic                  Mem_Write_Enable_o,
    output logic                  CPU_Reset_n_o,
    output logic                  Busy_o,
    output logic                  Load_Done_o,
    output logic                  Load_Error_o,
    output logic [15:0]           Words_Loaded_o
);

    localparam int          LANES   = DATA_WIDTH / 8;
    localparam int          WIDX_W  = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [15:0] DEPTH16 = 16'(MEMORY_DEPTH);
    localparam logic [1:0]  LAST_BYTE = 2'(LANES - 1);

    typedef enum logic [1:0] {
        RUN,
        COLLECT,
        WRITE,
        DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [15:0]           count_reg, count_next;
    logic [1:0]            byte_idx_reg, byte_idx_next;
    logic [WIDX_W-1:0]     word_idx_reg, word_idx_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic [15:0]           words_loaded_reg, words_loaded_next;
    logic                  error_reg, error_next;
    logic                  byte_accept;
    logic [31:0]           load_address;

    assign byte_accept = (state_reg == COLLECT) && Byte_Valid_i;

    // Each byte lane captures the incoming byte only when the byte index points at it.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign data_next[8*gi +: 8] =
                (byte_accept && (byte_idx_reg == 2'(gi))) ? Byte_i : data_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= RUN;
            count_reg        <= '0;
            byte_idx_reg     <= '0;
            word_idx_reg     <= '0;
            data_reg         <= '0;
            words_loaded_reg <= '0;
            error_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            count_reg        <= count_next;
            byte_idx_reg     <= byte_idx_next;
            word_idx_reg     <= word_idx_next;
            data_reg         <= data_next;
            words_loaded_reg <= words_loaded_next;
            error_reg        <= error_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        count_next        = count_reg;
        byte_idx_next     = byte_idx_reg;
        word_idx_next     = word_idx_reg;
        words_loaded_next = words_loaded_reg;
        error_next        = error_reg;

        case (state_reg)
            RUN: begin
                if (Load_Start_i) begin
                    if ((Word_Count_i == 16'd0) || (Word_Count_i > DEPTH16)) begin
                        error_next = 1'b1;
                    end else begin
                        count_next        = Word_Count_i;
                        error_next        = 1'b0;
                        words_loaded_next = '0;
                        byte_idx_next     = '0;
                        word_idx_next     = '0;
                        state_next        = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (byte_accept) begin
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == LAST_BYTE) begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                word_idx_next     = word_idx_reg + 1'b1;
                words_loaded_next = words_loaded_reg + 16'd1;
                byte_idx_next     = '0;
                // Count is bounded by MEMORY_DEPTH, so the word index never wraps before this hits.
                if ((words_loaded_reg + 16'd1) == count_reg) begin
                    state_next = DONE;
                end else begin
                    state_next = COLLECT;
                end
            end
            DONE: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign load_address = TEXT_BASE + {{(30 - WIDX_W){1'b0}}, word_idx_reg, 2'b00};

    always_comb begin
        Byte_Ready_o       = (state_reg == COLLECT);
        Mem_Write_Enable_o = (state_reg == WRITE);
        CPU_Reset_n_o      = (state_reg == RUN);
        Busy_o             = (state_reg != RUN);
        Load_Done_o        = (state_reg == DONE);
        Mem_Address_o      = (state_reg == RUN) ? PC_i : load_address;
    end

    assign Mem_Write_Data_o = data_reg;
    assign Load_Error_o     = error_reg;
    assign Words_Loaded_o   = words_loaded_reg;

endmodule

// File: tb/tb_program_memory_loader.sv
// Scoreboard bench: stimulus queues expected writes/done pulses, a negedge monitor checks them.
module tb_program_memory_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        Load_Start_i;
    logic [15:0] Word_Count_i;
    logic [7:0]  Byte_i;
    logic        Byte_Valid_i;
    logic        Byte_Ready_o;
    logic [31:0] PC_i;
    logic [31:0] Mem_Address_o;
    logic [31:0] Mem_Write_Data_o;
    logic        Mem_Write_Enable_o;
    logic        CPU_Reset_n_o;
    logic        Busy_o;
    logic        Load_Done_o;
    logic        Load_Error_o;
    logic [15:0] Words_Loaded_o;

    program_memory_loader dut (
        .clk                (clk),
        .reset              (reset),
        .Load_Start_i       (Load_Start_i),
        .Word_Count_i       (Word_Count_i),
        .Byte_i             (Byte_i),
        .Byte_Valid_i       (Byte_Valid_i),
        .Byte_Ready_o       (Byte_Ready_o),
        .PC_i               (PC_i),
        .Mem_Address_o      (Mem_Address_o),
        .Mem_Write_Data_o   (Mem_Write_Data_o),
        .Mem_Write_Enable_o (Mem_Write_Enable_o),
        .CPU_Reset_n_o      (CPU_Reset_n_o),
        .Busy_o             (Busy_o),
        .Load_Done_o        (Load_Done_o),
        .Load_Error_o       (Load_Error_o),
        .Words_Loaded_o     (Words_Loaded_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] words;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_wr_cyc = -10;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_write(input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.is_done = 1'b0; e.addr = addr; e.data = data; e.words = '0;
        q.push_back(e);
    endtask

    task automatic push_done(input logic [15:0] words);
        exp_t e;
        e.is_done = 1'b1; e.addr = '0; e.data = '0; e.words = words;
        q.push_back(e);
    endtask

    // Monitor: every write strobe and done pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (Mem_Write_Enable_o) begin
            $display("write addr=%h data=%h", Mem_Address_o, Mem_Write_Data_o);
            if (q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("write_kind", {31'd0, e.is_done}, 32'd0);
                chk("write_addr", Mem_Address_o, e.addr);
                chk("write_data", Mem_Write_Data_o, e.data);
            end
            last_wr_cyc = cyc;
        end
        if (Load_Done_o) begin
            $display("done words=%0d", Words_Loaded_o);
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("done_kind", {31'd0, e.is_done}, 32'd1);
                chk("done_words", {16'd0, Words_Loaded_o}, {16'd0, e.words});
                chk("done_latency", cyc, last_wr_cyc + 1);
                chk("done_cpu_rst", {31'd0, CPU_Reset_n_o}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [15:0] cnt);
        Load_Start_i = 1'b1;
        Word_Count_i = cnt;
        tick();
        Load_Start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        Byte_i = b;
        Byte_Valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (Byte_Ready_o) begin
                tick();
                ok = 1;
                break;
            end
            tick();
        end
        Byte_Valid_i = 1'b0;
        if (!ok) chk("byte_accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (!Busy_o) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        Load_Start_i = 1'b0;
        Word_Count_i = '0;
        Byte_i = '0;
        Byte_Valid_i = 1'b0;
        PC_i = 32'h0040_0008;
        tick();
        chk("rst_cpu_rst_n", {31'd0, CPU_Reset_n_o}, 32'd1);
        chk("rst_busy", {31'd0, Busy_o}, 32'd0);
        chk("rst_ready", {31'd0, Byte_Ready_o}, 32'd0);
        chk("rst_data", Mem_Write_Data_o, 32'd0);
        chk("rst_words", {16'd0, Words_Loaded_o}, 32'd0);
        chk("rst_error", {31'd0, Load_Error_o}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // RUN passthrough, zero latency
        chk("run_addr", Mem_Address_o, 32'h0040_0008);
        PC_i = 32'h0040_0010;
        #1;
        chk("run_addr_comb", Mem_Address_o, 32'h0040_0010);

        // Two-word back-to-back load
        push_write(32'h0040_0000, 32'h0000_0513);
        push_write(32'h0040_0004, 32'h0010_0093);
        push_done(16'd2);
        start_load(16'd2);
        chk("load_busy", {31'd0, Busy_o}, 32'd1);
        chk("load_cpu_rst", {31'd0, CPU_Reset_n_o}, 32'd0);
        send_word(32'h0000_0513);
        send_word(32'h0010_0093);
        wait_idle();
        chk("l1_words", {16'd0, Words_Loaded_o}, 32'd2);
        chk("l1_cpu_rst", {31'd0, CPU_Reset_n_o}, 32'd1);
        chk("l1_addr_pc", Mem_Address_o, 32'h0040_0010);

        // Same load with a 5-cycle gap between bytes 1 and 2
        push_write(32'h0040_0000, 32'h0000_0513);
        push_write(32'h0040_0004, 32'h0010_0093);
        push_done(16'd2);
        start_load(16'd2);
        send_byte(8'h13);
        send_byte(8'h05);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("gap_we", {31'd0, Mem_Write_Enable_o}, 32'd0);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        send_word(32'h0010_0093);
        wait_idle();
        chk("l2_words", {16'd0, Words_Loaded_o}, 32'd2);

        // Illegal counts
        start_load(16'd0);
        chk("err0_flag", {31'd0, Load_Error_o}, 32'd1);
        chk("err0_busy", {31'd0, Busy_o}, 32'd0);
        start_load(16'd65);
        chk("err65_flag", {31'd0, Load_Error_o}, 32'd1);
        chk("err65_busy", {31'd0, Busy_o}, 32'd0);
        chk("err65_addr", Mem_Address_o, 32'h0040_0010);
        push_write(32'h0040_0000, 32'h0000_0537);
        push_done(16'd1);
        start_load(16'd1);
        chk("err_cleared", {31'd0, Load_Error_o}, 32'd0);
        chk("err_clr_busy", {31'd0, Busy_o}, 32'd1);
        send_word(32'h0000_0537);
        wait_idle();
        chk("l3_words", {16'd0, Words_Loaded_o}, 32'd1);

        // Reset after six bytes of a four-word load
        push_write(32'h0040_0000, 32'h4433_2211);
        start_load(16'd4);
        send_word(32'h4433_2211);
        send_byte(8'h55);
        send_byte(8'h66);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, Busy_o}, 32'd0);
        chk("abort_cpu_rst", {31'd0, CPU_Reset_n_o}, 32'd1);
        chk("abort_words", {16'd0, Words_Loaded_o}, 32'd0);
        chk("abort_data", Mem_Write_Data_o, 32'd0);
        chk("abort_ready", {31'd0, Byte_Ready_o}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Load_Start mid-load is ignored
        push_write(32'h0040_0000, 32'h0000_0013);
        push_write(32'h0040_0004, 32'h0010_0093);
        push_write(32'h0040_0008, 32'h0020_0113);
        push_done(16'd3);
        start_load(16'd3);
        send_byte(8'h13);
        send_byte(8'h00);
        start_load(16'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        send_word(32'h0010_0093);
        send_word(32'h0020_0113);
        wait_idle();
        chk("l4_words", {16'd0, Words_Loaded_o}, 32'd3);

        tick();
        tick();
        chk("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
